// File: rtl/umi_write_arb_if.sv
// umi_write_arb_if
//   Bundles the requester-side and converter-side signals of umi_write_arb.
//   N  : number of requesters (2..8)
//   PW : UMI packet width
// Signals
//   in_packet   [N*PW] requester packets, port i at [i*PW +: PW]
//   in_valid    [N]    per-requester valid, held until matching in_ready
//   in_ready    [N]    per-requester completion pulse
//   out_packet  [PW]   packet to the converter
//   out_valid          valid to the converter
//   out_ready          converter completion pulse (1 cycle)
//   grant       [N]    one-hot current grant, zero when idle
//   busy               arbiter holds a grant
//   grant_count [N*32] per-port completed-transaction counters
// Modports
//   slave  : the arbiter side
//   master : the environment (requesters + converter) side
interface umi_write_arb_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 256
);
  logic [N*PW-1:0] in_packet;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [PW-1:0]   out_packet;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic [N*32-1:0] grant_count;

  modport slave (
    input  in_packet, in_valid, out_ready,
    output in_ready, out_packet, out_valid, grant, busy, grant_count
  );

  modport master (
    output in_packet, in_valid, out_ready,
    input  in_ready, out_packet, out_valid, grant, busy, grant_count
  );
endinterface

// File: rtl/umi_write_arb.sv
// umi_write_arb
//   Round-robin arbiter sharing one write-only UMI-to-AXI converter among N
//   UMI write requesters. A grant is locked for a whole transaction and is
//   released on the converter's completion pulse (out_ready) or when the
//   granted requester drops its valid (abandon). Because the grant is cleared
//   on completion and re-arbitrated only from IDLE, out_valid always has at
//   least one low cycle between back-to-back packets.
// Ports
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : umi_write_arb_if.slave (requester and converter signals)
// Configuration
//   UMI_WRITE_ARB_CNT_EN : when defined, N 32-bit wrap-around completion
//                          counters drive grant_count; otherwise grant_count
//                          is tied to zero and no counter flops exist.
module umi_write_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 256
) (
  input logic          clk,
  input logic          rst,
  umi_write_arb_if.slave bus
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic            r_busy;
  logic [LW-1:0]   r_last;

  logic [LW-1:0]   w_gidx;
  logic            w_gvalid;
  logic            w_done;
  logic            w_req_any;
  logic [LW-1:0]   w_pick;
  logic [N-1:0]    w_pick_oh;
  int unsigned     w_best;
  logic [PW-1:0]   w_pkt;

  // Index of the granted port (grant is one-hot, so at most one bit hits).
  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_grant[i]) w_gidx = LW'(i);
    end
  end

  // Grant is zero in IDLE, so these are naturally quiet when idle.
  assign w_gvalid = |(r_grant & bus.in_valid);
  assign w_done   = w_gvalid & bus.out_ready;

  // Round-robin pick: each requester's distance from last+1 (mod N) is
  // computed and the smallest distance wins, equivalent to scanning
  // last+1, last+2, ... with wrap-around.
  assign w_req_any = |bus.in_valid;

  always_comb begin
    w_pick = '0;
    w_best = N;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.in_valid[i] && (((i + N - 1 - 32'(r_last)) % N) < w_best)) begin
        w_best = (i + N - 1 - 32'(r_last)) % N;
        w_pick = LW'(i);
      end
    end
  end

  assign w_pick_oh = {{(N-1){1'b0}}, 1'b1} << w_pick;

  // Control FSM; grant, busy and last are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_last  <= LW'(N - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          // out_ready while idle is ignored.
          if (w_req_any) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick_oh;
            r_busy  <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Both completion and abandon release the grant and advance last.
          if (!w_gvalid || bus.out_ready) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= w_gidx;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Packet mux straight from the registered grant; all zero when idle.
  always_comb begin
    w_pkt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_grant[i]) w_pkt = bus.in_packet[i*PW +: PW];
    end
  end

  assign bus.out_packet = w_pkt;
  assign bus.out_valid  = w_gvalid;
  // in_ready is gated by the granted valid so an abandon never pulses it.
  assign bus.in_ready   = r_grant & bus.in_valid & {N{bus.out_ready}};
  assign bus.grant      = r_grant;
  assign bus.busy       = r_busy;

`ifdef UMI_WRITE_ARB_CNT_EN
  logic [31:0] r_cnt [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) r_cnt[i] <= '0;
    end else if (w_done) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_grant[i]) r_cnt[i] <= r_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    bus.grant_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.grant_count[i*32 +: 32] = r_cnt[i];
    end
  end
`else
  assign bus.grant_count = '0;
`endif

endmodule

// File: tb/tb_umi_write_arb.sv
module tb_umi_write_arb;
  localparam int N  = 4;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  umi_write_arb_if #(.N(N), .PW(PW)) bus ();

  umi_write_arb #(.N(N), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state (transaction level)
  bit          m_busy;
  int          m_g;
  int          m_last;
  int unsigned m_cnt [N];

  // Stimulus variables
  logic [PW-1:0] pkt [N];
  logic [N-1:0]  vld;
  logic          ordy;

  int order[$];

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic int unsigned exp_cnt(input int i);
`ifdef UMI_WRITE_ARB_CNT_EN
    return m_cnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock of the spec rules, evaluated with the inputs held this cycle.
  task automatic model_step();
    if (!m_busy) begin
      for (int s = 1; s <= N; s++) begin
        int p;
        p = (m_last + s) % N;
        if (!m_busy && vld[p]) begin
          m_busy = 1'b1;
          m_g    = p;
        end
      end
    end else if (!vld[m_g]) begin
      m_last = m_g;
      m_busy = 1'b0;
    end else if (ordy) begin
      m_cnt[m_g]++;
      m_last = m_g;
      m_busy = 1'b0;
    end
  endtask

  task automatic drive();
    bus.in_valid  = vld;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.in_packet[i*PW +: PW] = pkt[i];
  endtask

  task automatic check_all(input string ph);
    logic [N-1:0]  eg;
    logic          eov;
    logic [PW-1:0] ep;
    logic [N-1:0]  er;
    eg  = m_busy ? (N'(1) << m_g) : '0;
    eov = m_busy && vld[m_g];
    ep  = m_busy ? pkt[m_g] : '0;
    er  = (eov && ordy) ? eg : '0;
    chk({ph, ".grant"},    PW'(bus.grant),     PW'(eg));
    chk({ph, ".busy"},     PW'(bus.busy),      PW'(m_busy));
    chk({ph, ".out_valid"},PW'(bus.out_valid), PW'(eov));
    chk({ph, ".out_pkt"},  bus.out_packet,     ep);
    chk({ph, ".in_ready"}, PW'(bus.in_ready),  PW'(er));
    for (int i = 0; i < N; i++)
      chk({ph, ".cnt"}, PW'(bus.grant_count[i*32 +: 32]), PW'(exp_cnt(i)));
  endtask

  // Called at a falling edge with stimulus variables already set.
  task automatic tick(input string ph);
    drive();
    #1;
    check_all(ph);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    vld  = '0;
    ordy = 1'b0;
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit cact;
    int cwait;
    bit comp;
    int cg;
    bit eov;
    int gi;

    for (int i = 0; i < N; i++) pkt[i] = {$urandom, $urandom};
    rst  = 1'b1;
    vld  = '0;
    ordy = 1'b0;
    drive();
    model_reset();
    do_reset();

    // Single port 2, converter answers 3 cycles after out_valid
    pkt[2] = {$urandom, $urandom};
    vld = 4'b0100;
    tick("t1_req");
    drive(); #1;
    chk("t1_grant", PW'(bus.grant), PW'(4'b0100));
    chk("t1_ovalid", PW'(bus.out_valid), PW'(1'b1));
    tick("t1_b0");
    tick("t1_b1");
    tick("t1_b2");
    ordy = 1'b1;
    drive(); #1;
    chk("t1_in_ready", PW'(bus.in_ready), PW'(4'b0100));
    tick("t1_done");
    vld = '0; ordy = 1'b0;
    drive(); #1;
    chk("t1_gap", PW'(bus.out_valid), PW'(1'b0));
`ifdef UMI_WRITE_ARB_CNT_EN
    chk("t1_cnt2", PW'(bus.grant_count[2*32 +: 32]), PW'(32'd1));
`else
    chk("t1_cnt2", PW'(bus.grant_count[2*32 +: 32]), PW'(32'd0));
`endif
    tick("t1_idle");

    // Fairness: everybody requests continuously
    do_reset();
    vld = 4'b1111;
    order.delete();
    comp = 1'b0;
    for (int cyc = 0; cyc < 200 && order.size() < 8; cyc++) begin
      ordy = m_busy;
      drive(); #1;
      if (comp) chk("fair_gap", PW'(bus.out_valid), PW'(1'b0));
      comp = bus.out_valid && ordy;
      if (comp) order.push_back(oh2i(bus.grant));
      tick("fair");
    end
    chk("fair_n", PW'(order.size()), PW'(8));
    for (int k = 0; k < order.size(); k++) chk("fair_order", PW'(order[k]), PW'(k % 4));
    vld = '0; ordy = 1'b0;
    tick("fair_end");

    // Wrap: last is now 3, ports 1 and 3 request
    vld = 4'b1010;
    order.delete();
    for (int cyc = 0; cyc < 50 && order.size() < 2; cyc++) begin
      ordy = m_busy;
      drive(); #1;
      comp = bus.out_valid && ordy;
      gi   = oh2i(bus.grant);
      if (comp) order.push_back(gi);
      tick("wrap");
      if (comp && gi >= 0) vld[gi] = 1'b0;
    end
    chk("wrap_n", PW'(order.size()), PW'(2));
    if (order.size() == 2) begin
      chk("wrap_first", PW'(order[0]), PW'(1));
      chk("wrap_second", PW'(order[1]), PW'(3));
    end
    vld = '0; ordy = 1'b0;
    tick("wrap_end");

    // Abandon: port 0 granted then drops, port 2 waiting
    vld = 4'b0001;
    tick("ab_req");
    vld = 4'b0100;
    drive(); #1;
    chk("ab_grant0", PW'(bus.grant), PW'(4'b0001));
    chk("ab_no_ready", PW'(bus.in_ready), PW'(4'b0000));
    tick("ab_drop");
    drive(); #1;
    chk("ab_idle", PW'(bus.busy), PW'(1'b0));
    tick("ab_idle");
    drive(); #1;
    chk("ab_next", PW'(bus.grant), PW'(4'b0100));
    ordy = 1'b1;
    tick("ab_done");
    vld = '0; ordy = 1'b0;
    tick("ab_end");

    // Asynchronous reset in the middle of a transaction
    vld = 4'b0011;
    tick("ar_req");
    drive(); #1;
    chk("ar_ov_before", PW'(bus.out_valid), PW'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ov_drop", PW'(bus.out_valid), PW'(1'b0));
    chk("ar_grant_drop", PW'(bus.grant), PW'(4'b0000));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick("ar_idle");
    drive(); #1;
    chk("ar_port0", PW'(bus.grant), PW'(4'b0001));
    vld = '0;
    tick("ar_abandon");
    tick("ar_end");

    // Stray out_ready while idle
    ordy = 1'b1;
    drive(); #1;
    chk("stray_ready", PW'(bus.in_ready), PW'(4'b0000));
    tick("stray");
    ordy = 1'b0;
    drive(); #1;
    chk("stray_idle", PW'(bus.busy), PW'(1'b0));
    tick("stray_end");

    // Random traffic against the model
    cact = 1'b0;
    cwait = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          pkt[i] = {$urandom, $urandom};
        end
      end
      if (m_busy && vld[m_g] && $urandom_range(0, 49) == 0) vld[m_g] = 1'b0;
      eov = m_busy && vld[m_g];
      if (eov) begin
        if (!cact) begin
          cact  = 1'b1;
          cwait = $urandom_range(0, 3);
        end
        if (cwait == 0) begin
          ordy = 1'b1;
          cact = 1'b0;
        end else begin
          ordy = 1'b0;
          cwait--;
        end
      end else begin
        cact = 1'b0;
        ordy = !m_busy && ($urandom_range(0, 9) == 0);
      end
      comp = eov && ordy;
      cg   = m_g;
      tick("rnd");
      if (comp) vld[cg] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
